// File: rtl/phy_bringup_seq.sv
// Power-up sequencer: PLL lock -> PHY hardware reset pulse -> Clause-22 MDIO writes -> core reset release.
// Build option PHY_BRINGUP_READBACK_EN adds read-back of every written register with a sticky error flag.
module phy_bringup_seq #(
    parameter int unsigned RST_HOLD_CYCLES = 1250000,
    parameter int unsigned RST_WAIT_CYCLES = 6250000,
    parameter int unsigned MDC_DIV         = 32,
    parameter logic [4:0]  PHY_ADDR        = 5'd0,
    parameter int unsigned NUM_WR          = 2,
    parameter logic [4:0]  WR0_REG         = 5'd0,
    parameter logic [15:0] WR0_DATA        = 16'h0000,
    parameter logic [4:0]  WR1_REG         = 5'd0,
    parameter logic [15:0] WR1_DATA        = 16'h0000
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic phy_rst_n,
    output logic core_rst,
    output logic mdc,
    output logic mdio_o,
    output logic mdio_t,
    input  logic mdio_i,
    output logic done,
    output logic error
);

    localparam int unsigned CNT_MAX = (RST_HOLD_CYCLES > RST_WAIT_CYCLES) ? RST_HOLD_CYCLES : RST_WAIT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DIV_W   = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
    localparam int unsigned HALF_W  = 7;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_RST_ASSERT,
        ST_RST_WAIT,
        ST_MDIO_WR,
        ST_MDIO_GAP,
        ST_MDIO_RD,
        ST_RD_GAP,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                lock_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [1:0]          idx_q, idx_d;
    logic                half_tick;
    logic                wr_more;
    logic [63:0]         frame_w;
    logic                phy_rst_n_q, phy_rst_n_d;
    logic                core_rst_q, core_rst_d;
    logic                mdc_q, mdc_d;
    logic                mdio_o_q, mdio_o_d;
    logic                mdio_t_q, mdio_t_d;
    logic                done_q, done_d;

    function automatic logic [4:0] wr_reg(input logic [1:0] i);
        return (i == 2'd0) ? WR0_REG : WR1_REG;
    endfunction

    function automatic logic [15:0] wr_data(input logic [1:0] i);
        return (i == 2'd0) ? WR0_DATA : WR1_DATA;
    endfunction

    assign lock_s    = sync_q[1];
    assign half_tick = (div_q == DIV_W'(MDC_DIV - 1));
    assign wr_more   = (32'(idx_q) + 32'd1) < NUM_WR;

`ifdef PHY_BRINGUP_READBACK_EN
    logic [15:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic [63:0] frame_r;
`else
    logic unused_mdio_i;
    assign unused_mdio_i = mdio_i;
`endif

    // pll_locked is asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], pll_locked};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT_LOCK;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        half_d  = half_q;
        idx_d   = idx_q;
`ifdef PHY_BRINGUP_READBACK_EN
        rd_d    = rd_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_WAIT_LOCK: if (lock_s) state_d = ST_RST_ASSERT;
            ST_RST_ASSERT: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == CNT_W'(RST_WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (NUM_WR == 0) ? ST_DONE : ST_MDIO_WR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // half_q counts MDC half-periods; a frame is 128 halves and wraps back to 0
            ST_MDIO_WR: begin
                div_d = half_tick ? '0 : div_q + 1'b1;
                if (half_tick) begin
                    half_d = half_q + 1'b1;
                    if (&half_q) state_d = ST_MDIO_GAP;
                end
            end
            ST_MDIO_GAP: begin
                div_d = half_tick ? '0 : div_q + 1'b1;
                if (half_tick) begin
                    half_d = half_q + 1'b1;
                    if (half_q[0]) begin
                        half_d = '0;
                        idx_d  = idx_q + 1'b1;
                        if (wr_more) begin
                            state_d = ST_MDIO_WR;
                        end else begin
`ifdef PHY_BRINGUP_READBACK_EN
                            idx_d   = '0;
                            state_d = ST_MDIO_RD;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
`ifdef PHY_BRINGUP_READBACK_EN
            ST_MDIO_RD: begin
                div_d = half_tick ? '0 : div_q + 1'b1;
                if (half_tick) begin
                    half_d = half_q + 1'b1;
                    // data bits occupy halves 96..127; sample as mdc rises
                    if ((half_q[6:5] == 2'b11) && !half_q[0]) rd_d = {rd_q[14:0], mdio_i};
                    if (&half_q) begin
                        state_d = ST_RD_GAP;
                        if (rd_q != wr_data(idx_q)) err_d = 1'b1;
                    end
                end
            end
            ST_RD_GAP: begin
                div_d = half_tick ? '0 : div_q + 1'b1;
                if (half_tick) begin
                    half_d = half_q + 1'b1;
                    if (half_q[0]) begin
                        half_d  = '0;
                        idx_d   = idx_q + 1'b1;
                        state_d = wr_more ? ST_MDIO_RD : ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_WAIT_LOCK;
        endcase
        // lock loss aborts everything except the sticky error
        if ((state_q != ST_WAIT_LOCK) && !lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            div_d   = '0;
            half_d  = '0;
            idx_d   = '0;
        end
    end

    // outputs are decoded from the next state so the registered pins line up with state_q
    always_comb begin
        phy_rst_n_d = 1'b0;
        core_rst_d  = 1'b1;
        mdc_d       = 1'b0;
        mdio_o_d    = 1'b1;
        mdio_t_d    = 1'b0;
        done_d      = 1'b0;
        frame_w     = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, wr_reg(idx_d), 2'b10, wr_data(idx_d)};
`ifdef PHY_BRINGUP_READBACK_EN
        frame_r     = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, wr_reg(idx_d), 18'h3FFFF};
`endif
        case (state_d)
            ST_RST_WAIT: phy_rst_n_d = 1'b1;
            ST_MDIO_WR: begin
                phy_rst_n_d = 1'b1;
                mdc_d       = half_d[0];
                mdio_t_d    = 1'b1;
                mdio_o_d    = frame_w[~half_d[6:1]];
            end
            ST_MDIO_GAP, ST_RD_GAP: begin
                phy_rst_n_d = 1'b1;
                mdc_d       = half_d[0];
            end
`ifdef PHY_BRINGUP_READBACK_EN
            ST_MDIO_RD: begin
                phy_rst_n_d = 1'b1;
                mdc_d       = half_d[0];
                mdio_t_d    = (half_d[6:1] < 6'd46);
                mdio_o_d    = frame_r[~half_d[6:1]];
            end
`endif
            ST_DONE: begin
                phy_rst_n_d = 1'b1;
                core_rst_d  = 1'b0;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            div_q       <= '0;
            half_q      <= '0;
            idx_q       <= '0;
            phy_rst_n_q <= 1'b0;
            core_rst_q  <= 1'b1;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            half_q      <= half_d;
            idx_q       <= idx_d;
            phy_rst_n_q <= phy_rst_n_d;
            core_rst_q  <= core_rst_d;
            mdc_q       <= mdc_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            done_q      <= done_d;
        end
    end

`ifdef PHY_BRINGUP_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign phy_rst_n = phy_rst_n_q;
    assign core_rst  = core_rst_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;
    assign done      = done_q;

endmodule

// File: tb/tb_phy_bringup_seq.sv
// Directed bench for phy_bringup_seq: reset timing, MDIO frame scoreboard, lock loss, reset in DONE.
// Honors PHY_BRINGUP_READBACK_EN (read frames and a PHY read-data model).
module tb_phy_bringup_seq;

    localparam int unsigned HOLD = 100;
    localparam int unsigned WAIT = 200;
    localparam int unsigned DIV  = 2;
    localparam int unsigned NWR  = 2;
    localparam logic [4:0]  ADDR = 5'd1;
    localparam logic [4:0]  R0   = 5'h1F;
    localparam logic [15:0] D0   = 16'h0100;
    localparam logic [4:0]  R1   = 5'h00;
    localparam logic [15:0] D1   = 16'h1140;
    localparam logic [6:0]  RESET_VEC = 7'b0101000;
`ifdef PHY_BRINGUP_READBACK_EN
    localparam int DONE_LAT = 18 * 2 * DIV + 2 * DIV;
`else
    localparam int DONE_LAT = 2 * DIV;
`endif

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;
    logic phy_rst_n, core_rst, mdc, mdio_o, mdio_t, done, error;
    logic mdio_i = 1'b1;

    typedef struct {
        int          nbits;
        logic [63:0] bits;
    } frame_t;

    frame_t      exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_tfall = 0;
    logic [15:0] phy_rd1f, phy_rd00;
    logic        prev_core;

    logic        mdc_p, t_p;
    logic [63:0] sh;
    int          nb, thi, resp_idx;
    logic [17:0] resp;
    frame_t      f_mon;

    phy_bringup_seq #(
        .RST_HOLD_CYCLES(HOLD), .RST_WAIT_CYCLES(WAIT), .MDC_DIV(DIV), .PHY_ADDR(ADDR),
        .NUM_WR(NWR), .WR0_REG(R0), .WR0_DATA(D0), .WR1_REG(R1), .WR1_DATA(D1)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .phy_rst_n(phy_rst_n),
        .core_rst(core_rst), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t),
        .mdio_i(mdio_i), .done(done), .error(error)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {phy_rst_n, core_rst, mdc, mdio_o, mdio_t, done, error};
    endfunction

    function automatic logic sigv(input int sel);
        case (sel)
            0:       return phy_rst_n;
            1:       return mdio_t;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int max, output int n);
        n = 0;
        do begin
            prev_core = core_rst;
            @(negedge clk);
            n++;
        end while (sigv(sel) !== val && n < max);
    endtask

    task automatic push_run();
        frame_t f;
        for (int i = 0; i < int'(NWR); i++) begin
            f.nbits = 64;
            f.bits  = {32'hFFFF_FFFF, 2'b01, 2'b01, ADDR, (i == 0) ? R0 : R1, 2'b10, (i == 0) ? D0 : D1};
            exp_q.push_back(f);
        end
`ifdef PHY_BRINGUP_READBACK_EN
        for (int i = 0; i < int'(NWR); i++) begin
            f.nbits = 46;
            f.bits  = {18'd0, 32'hFFFF_FFFF, 2'b01, 2'b10, ADDR, (i == 0) ? R0 : R1};
            exp_q.push_back(f);
        end
`endif
    endtask

    // MDIO monitor and PHY read-data model, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (rst) begin
            mdc_p = 1'b0; t_p = 1'b0; sh = '0; nb = 0; thi = 0; resp_idx = -1; mdio_i = 1'b1;
        end else begin
            if (mdio_t) begin
                thi++;
                if (mdc && !mdc_p) begin
                    sh = {sh[62:0], mdio_o};
                    nb++;
                end
            end
            if (resp_idx >= 0 && mdc_p && !mdc) begin
                if (resp_idx == 0) begin
                    resp_idx = -1;
                    mdio_i   = 1'b1;
                end else begin
                    resp_idx--;
                    mdio_i = resp[resp_idx];
                end
            end
            if (t_p && !mdio_t) begin
                last_tfall = cyc;
                if (nb == 64 || nb == 46) begin
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", 64'(nb), 64'd0);
                    end else begin
                        f_mon = exp_q.pop_front();
                        check("frame_bits", sh, f_mon.bits);
                        check("frame_len", 64'(nb), 64'(f_mon.nbits));
                        if (nb == 64) check("frame_cycles", 64'(thi), 64'(128 * DIV));
                    end
                    if (nb == 46) begin
                        resp     = {2'b10, (sh[4:0] == 5'h1F) ? phy_rd1f : phy_rd00};
                        resp_idx = 17;
                        mdio_i   = resp[17];
                    end
                end
                sh = '0; nb = 0; thi = 0;
            end
            mdc_p = mdc;
            t_p   = mdio_t;
        end
    end

    initial begin
        int n;
        rst = 1'b1; pll_locked = 1'b0; phy_rd1f = D0; phy_rd00 = D1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs()), 64'(RESET_VEC));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("wait_lock_hold", 64'(outs()), 64'(RESET_VEC));

        // first lock, aborted mid-frame by a one-cycle lock drop
        push_run();
        pll_locked = 1'b1;
        wait_for(0, 1'b1, HOLD + 50, n);
        check("rst_hold_latency", 64'(n), 64'(3 + HOLD));
        check("core_rst_in_wait", 64'(core_rst), 64'd1);
        wait_for(1, 1'b1, WAIT + 50, n);
        check("first_frame_latency", 64'(n), 64'(WAIT));
        check("core_rst_in_frame", 64'(core_rst), 64'd1);
        repeat (40 * 2 * DIV) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_for(0, 1'b0, 10, n);
        check("lock_loss_latency", 64'(n + 1), 64'd3);
        check("lock_loss_outputs", 64'({phy_rst_n, core_rst, mdio_t, done}), 64'(4'b0100));
        exp_q.delete();
        push_run();
        wait_for(0, 1'b1, HOLD + 50, n);
        check("relock_hold_latency", 64'(n), 64'(HOLD + 1));
        wait_for(1, 1'b1, WAIT + 50, n);
        check("relock_frame_latency", 64'(n), 64'(WAIT));
        wait_for(2, 1'b1, 4000, n);
        check("done_latency", 64'(cyc - last_tfall), 64'(DONE_LAT));
        check("done_outputs", 64'({phy_rst_n, core_rst, mdc, mdio_t, done}), 64'(5'b10001));
        check("core_rst_before_done", 64'(prev_core), 64'd1);
        check("frames_drained", 64'(exp_q.size()), 64'd0);
        check("error_on_match", 64'(error), 64'd0);
        repeat (20) @(negedge clk);
        check("done_terminal", 64'({core_rst, mdc, mdio_t, done}), 64'(4'b0001));

        // reset while DONE, then a rerun with a mismatching read value for reg 00
        phy_rd00 = D1 ^ 16'h0001;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_in_done", 64'(outs()), 64'(RESET_VEC));
        @(negedge clk);
        rst = 1'b0;
        push_run();
        wait_for(0, 1'b1, HOLD + 50, n);
        check("restart_hold_latency", 64'(n), 64'(3 + HOLD));
        wait_for(2, 1'b1, 4000, n);
        check("done_run2", 64'(done), 64'd1);
        check("frames_drained_run2", 64'(exp_q.size()), 64'd0);
`ifdef PHY_BRINGUP_READBACK_EN
        check("error_on_mismatch", 64'(error), 64'd1);
`else
        check("error_tied_low", 64'(error), 64'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
